note_scheduler: RTL

//   Sits between the note sources and the music box's data_rq/data_rd handshake.

---
 rtl/note_scheduler.sv | 78 +++++++
 1 files changed

// File: rtl/note_scheduler.sv
// note_scheduler: queues live (priority) and demo codes in a FIFO and serves one per music-box request with an inter-note gap
module note_scheduler #(
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NOTE_GAP = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] live_code,
  input  logic              live_valid,
  input  logic [CODE_W-1:0] demo_code,
  input  logic              demo_valid,
  output logic              demo_ack,
  input  logic              data_rq,
  output logic [CODE_W-1:0] sound_code,
  output logic              data_rd,
  output logic              overflow,
  output logic              busy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned GW = NOTE_GAP > 1 ? $clog2(NOTE_GAP + 1) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t r_state, w_next;
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [PW:0] r_count;
  logic [GW-1:0] r_gap;
  logic [CODE_W-1:0] r_sound;
  logic r_data_rd, r_demo_ack, r_overflow;
  logic w_pop, w_room, w_live_wr, w_demo_wr, w_wr;
  logic [CODE_W-1:0] w_wdata;
  assign w_pop     = r_state == IDLE && data_rq && r_count != '0;
  assign w_room    = r_count != (PW+1)'(DEPTH) || w_pop;
  assign w_live_wr = live_valid && w_room;
  assign w_demo_wr = !live_valid && demo_valid && !r_demo_ack && w_room;
  assign w_wr      = w_live_wr || w_demo_wr;
  assign w_wdata   = live_valid ? live_code : demo_code;
  assign sound_code = r_sound;
  assign data_rd    = r_data_rd;
  assign demo_ack   = r_demo_ack;
  assign overflow   = r_overflow;
  assign busy       = r_count != '0 || r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = w_pop ? SEND :
             (r_state == SEND && !data_rq) ? (NOTE_GAP == 0 ? IDLE : GAP) :
             (r_state == GAP && r_gap == GW'(1)) ? IDLE : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_gap      <= '0;
      r_sound    <= '0;
      r_data_rd  <= 1'b0;
      r_demo_ack <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_data_rd  <= w_next == SEND;
      r_demo_ack <= w_demo_wr;
      r_count    <= r_count + (PW+1)'(w_wr) - (PW+1)'(w_pop);
      if (live_valid && !w_room) r_overflow <= 1'b1;
      if (w_wr) begin
        r_mem[r_wr] <= w_wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_sound <= r_mem[r_rd];
        r_rd    <= r_rd + 1'b1;
      end
      if (r_state == SEND && !data_rq) r_gap <= GW'(NOTE_GAP);
      else if (r_state == GAP) r_gap <= r_gap - 1'b1;
    end
  end
endmodule
